// File: rtl/yuv2rgb_seq.sv
// yuv2rgb_seq: sequential YUV->RGB converter sharing a single multiplier.
// Ports: clk, rst_n, start/busy/done handshake, inportY/U/V in, outportR/G/B out.
module yuv2rgb_seq #(
    parameter int BITS = 9,
    parameter int FRAC = 8,
    parameter int OFS  = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [BITS-1:0] inportY,
    input  logic [BITS-1:0] inportU,
    input  logic [BITS-1:0] inportV,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] outportR,
    output logic [BITS-1:0] outportG,
    output logic [BITS-1:0] outportB
);

    localparam int DW = BITS + 1;
    localparam int PW = 2 * BITS + 2;
    localparam int SW = BITS + 3;

    localparam logic signed [DW-1:0] OFS_S = DW'(OFS);
    localparam logic signed [DW-1:0] C_RV  = DW'(359);
    localparam logic signed [DW-1:0] C_GU  = DW'(88);
    localparam logic signed [DW-1:0] C_GV  = DW'(183);
    localparam logic signed [DW-1:0] C_BU  = DW'(454);
    localparam logic signed [SW-1:0] MAX_S = SW'((1 << BITS) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_M0,
        S_M1,
        S_M2,
        S_M3,
        S_SUM,
        S_CLIP,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [BITS-1:0]        y_q, y_d;
    logic signed [DW-1:0]   du_q, du_d;
    logic signed [DW-1:0]   dv_q, dv_d;
    logic signed [PW-1:0]   p0_q, p0_d;
    logic signed [PW-1:0]   p1_q, p1_d;
    logic signed [PW-1:0]   p2_q, p2_d;
    logic signed [PW-1:0]   p3_q, p3_d;
    logic signed [SW-1:0]   rs_q, rs_d;
    logic signed [SW-1:0]   gs_q, gs_d;
    logic signed [SW-1:0]   bs_q, bs_d;
    logic [BITS-1:0]        r_q, r_d;
    logic [BITS-1:0]        g_q, g_d;
    logic [BITS-1:0]        b_q, b_d;
    logic                   done_q, done_d;

    logic signed [DW-1:0]   mul_a;
    logic signed [DW-1:0]   mul_c;
    logic signed [PW-1:0]   prod;
    logic signed [PW:0]     gsum;
    logic signed [SW-1:0]   ys;

    function automatic logic [BITS-1:0] clamp(input logic signed [SW-1:0] x);
        if (x < 0)
            return '0;
        else if (x > MAX_S)
            return MAX_S[BITS-1:0];
        else
            return x[BITS-1:0];
    endfunction

    // Shared multiplier: operand and coefficient are steered by state.
    always_comb begin
        mul_a = dv_q;
        mul_c = '0;
        unique case (state_q)
            S_M0:    begin mul_a = dv_q; mul_c = C_RV; end
            S_M1:    begin mul_a = du_q; mul_c = C_GU; end
            S_M2:    begin mul_a = dv_q; mul_c = C_GV; end
            S_M3:    begin mul_a = du_q; mul_c = C_BU; end
            default: begin mul_a = dv_q; mul_c = '0;   end
        endcase
    end

    assign prod = PW'(mul_a) * PW'(mul_c);
    // Green subtracts the floor of the combined sum, not of each term.
    assign gsum = (PW + 1)'(p1_q) + (PW + 1)'(p2_q);
    assign ys   = $signed(SW'(y_q));

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        du_d    = du_q;
        dv_d    = dv_q;
        p0_d    = p0_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        p3_d    = p3_q;
        rs_d    = rs_q;
        gs_d    = gs_q;
        bs_d    = bs_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    y_d     = inportY;
                    du_d    = $signed({1'b0, inportU}) - OFS_S;
                    dv_d    = $signed({1'b0, inportV}) - OFS_S;
                    state_d = S_M0;
                end
            end
            S_M0: begin
                p0_d    = prod;
                state_d = S_M1;
            end
            S_M1: begin
                p1_d    = prod;
                state_d = S_M2;
            end
            S_M2: begin
                p2_d    = prod;
                state_d = S_M3;
            end
            S_M3: begin
                p3_d    = prod;
                state_d = S_SUM;
            end
            S_SUM: begin
                rs_d    = ys + SW'(p0_q >>> FRAC);
                gs_d    = ys - SW'(gsum >>> FRAC);
                bs_d    = ys + SW'(p3_q >>> FRAC);
                state_d = S_CLIP;
            end
            S_CLIP: begin
                r_d     = clamp(rs_q);
                g_d     = clamp(gs_q);
                b_d     = clamp(bs_q);
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            y_q     <= '0;
            du_q    <= '0;
            dv_q    <= '0;
            p0_q    <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            p3_q    <= '0;
            rs_q    <= '0;
            gs_q    <= '0;
            bs_q    <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            du_q    <= du_d;
            dv_q    <= dv_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            p3_q    <= p3_d;
            rs_q    <= rs_d;
            gs_q    <= gs_d;
            bs_q    <= bs_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign outportR = r_q;
    assign outportG = g_q;
    assign outportB = b_q;

endmodule
